// File: rtl/axi_rd_arbiter.sv
// Two-requester arbiter sharing one AXI4 read channel; one burst in flight at a time.
// Build macro AXI_RD_ARB_WEIGHT_PRIO_EN: req1 gets strict priority instead of round-robin.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512,
  parameter int LEN_W  = 8
) (
  input  logic              system_clk,
  input  logic              rst,

  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_len,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_rvalid,
  output logic              req0_rlast,
  input  logic              req0_rready,
  output logic              req0_done,

  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_rvalid,
  output logic              req1_rlast,
  input  logic              req1_rready,
  output logic              req1_done,

  output logic              rd_err,

  output logic [ADDR_W-1:0] m00_axi_araddr,
  output logic [LEN_W-1:0]  m00_axi_arlen,
  output logic [2:0]        m00_axi_arsize,
  output logic [1:0]        m00_axi_arburst,
  output logic              m00_axi_arvalid,
  input  logic              m00_axi_arready,
  input  logic [DATA_W-1:0] m00_axi_rdata,
  input  logic [1:0]        m00_axi_rresp,
  input  logic              m00_axi_rlast,
  input  logic              m00_axi_rvalid,
  output logic              m00_axi_rready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q,    state_d;
  logic              gnt_q,      gnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] araddr_q,   araddr_d;
  logic [LEN_W-1:0]  arlen_q,    arlen_d;
  logic              arvalid_q,  arvalid_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [1:0]        ready_q,    ready_d;
  logic [1:0]        done_q,     done_d;
  logic              rd_err_q,   rd_err_d;

  logic in_data_s;
  logic rready_sel_s;
  logic beat_hs_s;
  logic req_any_s;
  logic pick_s;

  assign in_data_s    = (state_q == ST_DATA);
  assign rready_sel_s = gnt_q ? req1_rready : req0_rready;
  assign beat_hs_s    = in_data_s & rready_sel_s & m00_axi_rvalid;
  assign req_any_s    = req0_valid | req1_valid;

  // Grant selection among pending requesters in IDLE.
  always_comb begin
    pick_s = 1'b0;
`ifdef AXI_RD_ARB_WEIGHT_PRIO_EN
    pick_s = req1_valid;
`else
    if (req0_valid && req1_valid) begin
      pick_s = ~last_gnt_q;
    end else begin
      pick_s = req1_valid;
    end
`endif
  end

  // Next-state logic for the IDLE -> AR -> DATA burst sequence.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arvalid_d  = arvalid_q;
    beat_cnt_d = beat_cnt_q;
    ready_d    = 2'b00;
    done_d     = 2'b00;
    rd_err_d   = rd_err_q;

    case (state_q)
      ST_IDLE: begin
        arvalid_d = 1'b0;
        if (req_any_s) begin
          gnt_d    = pick_s;
          araddr_d = pick_s ? req1_addr : req0_addr;
          arlen_d  = pick_s ? req1_len : req0_len;
          ready_d  = pick_s ? 2'b10 : 2'b01;
          state_d  = ST_AR;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // arvalid rises one cycle after the accept pulse, giving the 2-cycle request latency.
      ST_AR: begin
        if (arvalid_q && m00_axi_arready) begin
          arvalid_d  = 1'b0;
          beat_cnt_d = {LEN_W{1'b0}};
          state_d    = ST_DATA;
        end else begin
          arvalid_d = 1'b1;
        end
      end

      ST_DATA: begin
        arvalid_d = 1'b0;
        if (beat_hs_s) begin
          beat_cnt_d = beat_cnt_q + LEN_ONE;
          // rlast must coincide exactly with the beat where the count reaches arlen.
          if ((m00_axi_rresp != 2'b00) || (m00_axi_rlast != (beat_cnt_q == arlen_q))) begin
            rd_err_d = 1'b1;
          end else begin
            rd_err_d = rd_err_q;
          end
          if (m00_axi_rlast) begin
            done_d     = gnt_q ? 2'b10 : 2'b01;
            last_gnt_d = gnt_q;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      default: begin
        arvalid_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge system_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      araddr_q   <= {ADDR_W{1'b0}};
      arlen_q    <= {LEN_W{1'b0}};
      arvalid_q  <= 1'b0;
      beat_cnt_q <= {LEN_W{1'b0}};
      ready_q    <= 2'b00;
      done_q     <= 2'b00;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arvalid_q  <= arvalid_d;
      beat_cnt_q <= beat_cnt_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign m00_axi_araddr  = araddr_q;
  assign m00_axi_arlen   = arlen_q;
  assign m00_axi_arsize  = 3'b110;
  assign m00_axi_arburst = 2'b01;
  assign m00_axi_arvalid = arvalid_q;
  assign m00_axi_rready  = in_data_s & rready_sel_s;

  assign req0_ready  = ready_q[0];
  assign req1_ready  = ready_q[1];
  assign req0_done   = done_q[0];
  assign req1_done   = done_q[1];
  assign rd_err      = rd_err_q;

  assign req0_rdata  = m00_axi_rdata;
  assign req1_rdata  = m00_axi_rdata;
  assign req0_rvalid = in_data_s & ~gnt_q & m00_axi_rvalid;
  assign req0_rlast  = in_data_s & ~gnt_q & m00_axi_rlast;
  assign req1_rvalid = in_data_s &  gnt_q & m00_axi_rvalid;
  assign req1_rlast  = in_data_s &  gnt_q & m00_axi_rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter; honours AXI_RD_ARB_WEIGHT_PRIO_EN for grant order.
module tb_axi_rd_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 512;
  localparam int LEN_W  = 8;

`ifdef AXI_RD_ARB_WEIGHT_PRIO_EN
  localparam logic FIRST_GNT = 1'b1;
`else
  localparam logic FIRST_GNT = 1'b0;
`endif

  logic              system_clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [LEN_W-1:0]  req0_len, req1_len;
  logic              req0_ready, req1_ready;
  logic [DATA_W-1:0] req0_rdata, req1_rdata;
  logic              req0_rvalid, req1_rvalid, req0_rlast, req1_rlast;
  logic              req0_rready, req1_rready, req0_done, req1_done;
  logic              rd_err;
  logic [ADDR_W-1:0] m00_axi_araddr;
  logic [LEN_W-1:0]  m00_axi_arlen;
  logic [2:0]        m00_axi_arsize;
  logic [1:0]        m00_axi_arburst;
  logic              m00_axi_arvalid, m00_axi_arready;
  logic [DATA_W-1:0] m00_axi_rdata;
  logic [1:0]        m00_axi_rresp;
  logic              m00_axi_rlast, m00_axi_rvalid, m00_axi_rready;

  int total = 0;
  int bad   = 0;

  always #5 system_clk = ~system_clk;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .system_clk(system_clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
    .req0_rdata(req0_rdata), .req0_rvalid(req0_rvalid), .req0_rlast(req0_rlast),
    .req0_rready(req0_rready), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
    .req1_rdata(req1_rdata), .req1_rvalid(req1_rvalid), .req1_rlast(req1_rlast),
    .req1_rready(req1_rready), .req1_done(req1_done),
    .rd_err(rd_err),
    .m00_axi_araddr(m00_axi_araddr), .m00_axi_arlen(m00_axi_arlen), .m00_axi_arsize(m00_axi_arsize),
    .m00_axi_arburst(m00_axi_arburst), .m00_axi_arvalid(m00_axi_arvalid), .m00_axi_arready(m00_axi_arready),
    .m00_axi_rdata(m00_axi_rdata), .m00_axi_rresp(m00_axi_rresp), .m00_axi_rlast(m00_axi_rlast),
    .m00_axi_rvalid(m00_axi_rvalid), .m00_axi_rready(m00_axi_rready)
  );

  task automatic tick();
    @(posedge system_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_rready = 1'b1; req1_rready = 1'b1;
    m00_axi_arready = 1'b0; m00_axi_rvalid = 1'b0; m00_axi_rlast = 1'b0; m00_axi_rresp = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Raise a request and wait (bounded) for its accept pulse; lat is 20 on timeout.
  task automatic issue(input int who, input logic [31:0] addr, input logic [7:0] len,
                       output int lat, output logic other);
    lat = 0;
    other = 1'b0;
    if (who == 0) begin req0_valid = 1'b1; req0_addr = addr; req0_len = len; end
    else begin req1_valid = 1'b1; req1_addr = addr; req1_len = len; end
    while (lat < 20) begin
      tick();
      lat++;
      if (((who == 0) ? req1_ready : req0_ready) === 1'b1) other = 1'b1;
      if ((who == 0 && req0_ready === 1'b1) || (who == 1 && req1_ready === 1'b1)) break;
    end
    if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    #1;
  endtask

  // Slave side: accept AR, return nbeats beats (rlast on the final one); returns at the done cycle.
  task automatic serve(input int nbeats, input int err_at, output int b0, output int b1,
                       output logic d0, output logic d1, output logic to);
    int k;
    int sent;
    logic [31:0] w;
    b0 = 0; b1 = 0; d0 = 1'b0; d1 = 1'b0; to = 1'b0;
    k = 0;
    while (m00_axi_arvalid !== 1'b1 && k < 50) begin tick(); k++; end
    if (k >= 50) begin
      to = 1'b1;
    end else begin
      m00_axi_arready = 1'b1;
      tick();
      m00_axi_arready = 1'b0;
      sent = 0;
      k = 0;
      while (sent < nbeats && k < 200) begin
        w = 32'hC000_0000 + sent;
        m00_axi_rvalid = 1'b1;
        m00_axi_rdata  = {16{w}};
        m00_axi_rlast  = (sent == nbeats - 1);
        m00_axi_rresp  = (sent == err_at) ? 2'b10 : 2'b00;
        #1;
        if (m00_axi_rready === 1'b1) begin
          if (req0_rvalid === 1'b1 && req0_rready === 1'b1) b0++;
          if (req1_rvalid === 1'b1 && req1_rready === 1'b1) b1++;
          sent++;
        end
        tick();
        k++;
      end
      m00_axi_rvalid = 1'b0; m00_axi_rlast = 1'b0; m00_axi_rresp = 2'b00;
      if (k >= 200) to = 1'b1;
      d0 = req0_done;
      d1 = req1_done;
    end
  endtask

  task automatic test_reset();
    do_reset();
    m00_axi_rvalid = 1'b1; m00_axi_rlast = 1'b1;
    #1;
    total++;
    if ({m00_axi_arvalid, req0_ready, req1_ready, req0_done, req1_done, rd_err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000000", {m00_axi_arvalid, req0_ready, req1_ready, req0_done, req1_done, rd_err});
    end
    total++;
    if ({m00_axi_araddr, m00_axi_arlen} !== 40'h0) begin
      bad++; $display("FAIL reset_ar got=%h/%h want=0/0", m00_axi_araddr, m00_axi_arlen);
    end
    total++;
    if ({m00_axi_arsize, m00_axi_arburst} !== 5'b110_01) begin
      bad++; $display("FAIL reset_size_burst got=%b/%b want=110/01", m00_axi_arsize, m00_axi_arburst);
    end
    total++;
    if ({m00_axi_rready, req0_rvalid, req1_rvalid, req0_rlast, req1_rlast} !== 5'b0) begin
      bad++;
      $display("FAIL idle_rvalid_ignored got=%b want=00000", {m00_axi_rready, req0_rvalid, req1_rvalid, req0_rlast, req1_rlast});
    end
    tick();
    m00_axi_rvalid = 1'b0; m00_axi_rlast = 1'b0;
  endtask

  task automatic test_single_burst();
    logic [31:0] w;
    logic [DATA_W-1:0] exp_data;
    do_reset();
    req0_valid = 1'b1; req0_addr = 32'h1000; req0_len = 8'd3;
    #1;
    total++;
    if (req0_ready !== 1'b0) begin bad++; $display("FAIL single_ready_early got=%b want=0", req0_ready); end
    tick();
    total++;
    if ({req0_ready, req1_ready, m00_axi_arvalid} !== 3'b100) begin
      bad++; $display("FAIL single_accept got=%b want=100", {req0_ready, req1_ready, m00_axi_arvalid});
    end
    req0_valid = 1'b0;
    tick();
    total++;
    if ({m00_axi_arvalid, req0_ready, m00_axi_araddr, m00_axi_arlen} !== {1'b1, 1'b0, 32'h1000, 8'd3}) begin
      bad++;
      $display("FAIL single_ar got=%b%b/%h/%h want=10/00001000/03", m00_axi_arvalid, req0_ready, m00_axi_araddr, m00_axi_arlen);
    end
    m00_axi_arready = 1'b1;
    tick();
    m00_axi_arready = 1'b0;
    total++;
    if (m00_axi_arvalid !== 1'b0) begin bad++; $display("FAIL single_ar_once got=%b want=0", m00_axi_arvalid); end
    for (int i = 0; i < 4; i++) begin
      w = 32'hA000_0000 + i;
      exp_data = {16{w}};
      m00_axi_rvalid = 1'b1; m00_axi_rdata = exp_data; m00_axi_rlast = (i == 3);
      #1;
      total++;
      if ({req0_rvalid, req1_rvalid, m00_axi_rready, req0_rlast, req1_rlast, req0_done} !==
          {1'b1, 1'b0, 1'b1, (i == 3), 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL single_beat%0d got=%b want=101%b00", i,
                 {req0_rvalid, req1_rvalid, m00_axi_rready, req0_rlast, req1_rlast, req0_done}, (i == 3));
      end
      total++;
      if (req0_rdata !== exp_data) begin bad++; $display("FAIL single_rdata%0d got=%h want=%h", i, req0_rdata[31:0], w); end
      tick();
    end
    m00_axi_rvalid = 1'b0; m00_axi_rlast = 1'b0;
    total++;
    if ({req0_done, req1_done, rd_err} !== 3'b100) begin
      bad++; $display("FAIL single_done got=%b want=100", {req0_done, req1_done, rd_err});
    end
    tick();
    total++;
    if ({req0_done, req1_done} !== 2'b00) begin bad++; $display("FAIL single_done_pulse got=%b want=00", {req0_done, req1_done}); end
  endtask

  task automatic test_round_robin();
    int b0, b1;
    logic d0, d1, to;
    int e0, e1;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      req0_valid = 1'b1; req0_addr = 32'h3000 + r * 32'h100; req0_len = 8'd1;
      req1_valid = 1'b1; req1_addr = 32'h3800 + r * 32'h100; req1_len = 8'd1;
      tick();
      total++;
      if ({req1_ready, req0_ready} !== {FIRST_GNT, ~FIRST_GNT}) begin
        bad++; $display("FAIL rr%0d_first got=%b want=%b", r, {req1_ready, req0_ready}, {FIRST_GNT, ~FIRST_GNT});
      end
      if (FIRST_GNT) req1_valid = 1'b0; else req0_valid = 1'b0;
      serve(2, -1, b0, b1, d0, d1, to);
      e0 = FIRST_GNT ? 0 : 2;
      e1 = FIRST_GNT ? 2 : 0;
      total++;
      if (b0 != e0 || b1 != e1 || d0 !== ~FIRST_GNT || d1 !== FIRST_GNT || to !== 1'b0) begin
        bad++; $display("FAIL rr%0d_first_burst got=%0d,%0d,%b%b,%b want=%0d,%0d", r, b0, b1, d0, d1, to, e0, e1);
      end
      tick();
      total++;
      if ({req1_ready, req0_ready} !== {~FIRST_GNT, FIRST_GNT}) begin
        bad++; $display("FAIL rr%0d_second got=%b want=%b", r, {req1_ready, req0_ready}, {~FIRST_GNT, FIRST_GNT});
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      serve(2, -1, b0, b1, d0, d1, to);
      total++;
      if (b0 != e1 || b1 != e0 || d0 !== FIRST_GNT || d1 !== ~FIRST_GNT || to !== 1'b0) begin
        bad++; $display("FAIL rr%0d_second_burst got=%0d,%0d,%b%b,%b want=%0d,%0d", r, b0, b1, d0, d1, to, e1, e0);
      end
    end
  endtask

  task automatic test_stall_backpressure();
    int lat, stable_bad, follow_bad, r0_bad, seq_bad, got, c;
    logic oth;
    logic [31:0] w;
    logic [15:0] pat;
    do_reset();
    issue(1, 32'h2000, 8'd3, lat, oth);
    total++;
    if (lat != 1 || oth !== 1'b0) begin bad++; $display("FAIL stall_accept got=%0d,%b want=1,0", lat, oth); end
    tick();
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if ({m00_axi_arvalid, m00_axi_araddr, m00_axi_arlen} !== {1'b1, 32'h2000, 8'd3}) stable_bad++;
      tick();
    end
    total++;
    if (stable_bad != 0 || m00_axi_arvalid !== 1'b1) begin
      bad++; $display("FAIL stall_ar_stable got=%0d unstable,%b want=0,1", stable_bad, m00_axi_arvalid);
    end
    m00_axi_arready = 1'b1;
    tick();
    m00_axi_arready = 1'b0;
    pat = 16'b1111_1101_0110_1001;
    got = 0; c = 0; follow_bad = 0; r0_bad = 0; seq_bad = 0;
    while (got < 4 && c < 16) begin
      w = 32'hB000_0000 + got;
      m00_axi_rvalid = 1'b1; m00_axi_rdata = {16{w}}; m00_axi_rlast = (got == 3);
      req1_rready = pat[c];
      #1;
      if (m00_axi_rready !== pat[c]) follow_bad++;
      if (req0_rvalid !== 1'b0) r0_bad++;
      if (req1_rvalid === 1'b1 && req1_rready === 1'b1) begin
        if (req1_rdata[31:0] !== 32'hB000_0000 + got) seq_bad++;
        got++;
      end
      tick();
      c++;
    end
    m00_axi_rvalid = 1'b0; m00_axi_rlast = 1'b0; req1_rready = 1'b1;
    total++;
    if (follow_bad != 0 || r0_bad != 0) begin
      bad++; $display("FAIL stall_rready_follow got=%0d,%0d bad cycles want=0,0", follow_bad, r0_bad);
    end
    total++;
    if (got != 4 || c != 7 || seq_bad != 0) begin
      bad++; $display("FAIL stall_beats got=%0d beats in %0d cycles,%0d seq want=4 in 7,0", got, c, seq_bad);
    end
    total++;
    if ({req1_done, req0_done, rd_err} !== 3'b100) begin
      bad++; $display("FAIL stall_done got=%b want=100", {req1_done, req0_done, rd_err});
    end
  endtask

  task automatic test_len0_and_rresp();
    int lat, b0, b1;
    logic oth, d0, d1, to;
    do_reset();
    issue(0, 32'h4000, 8'd0, lat, oth);
    serve(1, -1, b0, b1, d0, d1, to);
    total++;
    if (lat != 1 || b0 != 1 || b1 != 0 || {d0, d1, to, rd_err} !== 4'b1000) begin
      bad++; $display("FAIL len0 got=%0d,%0d,%0d,%b want=1,1,0,1000", lat, b0, b1, {d0, d1, to, rd_err});
    end
    issue(1, 32'h5000, 8'd7, lat, oth);
    serve(8, 1, b0, b1, d0, d1, to);
    total++;
    if (b0 != 0 || b1 != 8 || {d0, d1, to, rd_err} !== 4'b0101) begin
      bad++; $display("FAIL rresp_err got=%0d,%0d,%b want=0,8,0101", b0, b1, {d0, d1, to, rd_err});
    end
    tick();
    issue(0, 32'h6000, 8'd1, lat, oth);
    serve(2, -1, b0, b1, d0, d1, to);
    total++;
    if (b0 != 2 || {d0, to, rd_err} !== 3'b101) begin
      bad++; $display("FAIL rd_err_sticky got=%0d,%b want=2,101", b0, {d0, to, rd_err});
    end
  endtask

  task automatic test_early_rlast();
    int lat, b0, b1;
    logic oth, d0, d1, to;
    do_reset();
    issue(0, 32'h7000, 8'd5, lat, oth);
    serve(3, -1, b0, b1, d0, d1, to);
    total++;
    if (b0 != 3 || {d0, d1, to, rd_err} !== 4'b1001) begin
      bad++; $display("FAIL early_rlast got=%0d,%b want=3,1001", b0, {d0, d1, to, rd_err});
    end
    issue(1, 32'h8000, 8'd1, lat, oth);
    serve(2, -1, b0, b1, d0, d1, to);
    total++;
    if (lat != 1 || b1 != 2 || {d0, d1, to} !== 3'b010) begin
      bad++; $display("FAIL early_rlast_next got=%0d,%0d,%b want=1,2,010", lat, b1, {d0, d1, to});
    end
  endtask

  task automatic test_reset_mid_burst();
    int lat, b0, b1;
    logic oth, d0, d1, to;
    do_reset();
    issue(0, 32'h9000, 8'd7, lat, oth);
    tick();
    m00_axi_arready = 1'b1;
    tick();
    m00_axi_arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m00_axi_rvalid = 1'b1; m00_axi_rlast = 1'b0;
      m00_axi_rresp = (i == 1) ? 2'b10 : 2'b00;
      tick();
    end
    m00_axi_rresp = 2'b00;
    total++;
    if ({rd_err, req0_rvalid} !== 2'b11) begin bad++; $display("FAIL mid_pre_rst got=%b want=11", {rd_err, req0_rvalid}); end
    rst = 1'b1;
    tick();
    total++;
    if ({m00_axi_arvalid, req0_ready, req1_ready, req0_done, req1_done, rd_err,
         m00_axi_rready, req0_rvalid, req1_rvalid, m00_axi_araddr, m00_axi_arlen} !== 49'h0) begin
      bad++;
      $display("FAIL mid_rst_outputs got=%b/%h/%h want=0",
               {m00_axi_arvalid, req0_ready, req1_ready, req0_done, req1_done, rd_err, m00_axi_rready, req0_rvalid, req1_rvalid},
               m00_axi_araddr, m00_axi_arlen);
    end
    rst = 1'b0;
    m00_axi_rvalid = 1'b0;
    issue(1, 32'hA000, 8'd2, lat, oth);
    total++;
    if (lat != 1 || m00_axi_araddr !== 32'hA000 || m00_axi_arlen !== 8'd2) begin
      bad++; $display("FAIL mid_new_req got=%0d,%h,%h want=1,0000a000,02", lat, m00_axi_araddr, m00_axi_arlen);
    end
    serve(3, -1, b0, b1, d0, d1, to);
    total++;
    if (b1 != 3 || b0 != 0 || {d0, d1, to, rd_err} !== 4'b0100) begin
      bad++; $display("FAIL mid_new_burst got=%0d,%0d,%b want=0,3,0100", b0, b1, {d0, d1, to, rd_err});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench watchdog");
  end

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = 32'h0; req1_addr = 32'h0; req0_len = 8'd0; req1_len = 8'd0;
    req0_rready = 1'b1; req1_rready = 1'b1;
    m00_axi_arready = 1'b0; m00_axi_rdata = {DATA_W{1'b0}}; m00_axi_rresp = 2'b00;
    m00_axi_rlast = 1'b0; m00_axi_rvalid = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_stall_backpressure();
    test_len0_and_rresp();
    test_early_rlast();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
